// File: rtl/uarttx_buffered.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// New frames start only while en=1; a frame that has begun always runs to its stop bit.
module uarttx_buffered #(
  parameter int BAUD_MULT  = 10416,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [1:0]                    out_state,
  output logic [$clog2(FIFO_DEPTH):0]   out_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BAUD_MULT > 1) ? $clog2(BAUD_MULT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_MULT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    mem [FIFO_DEPTH];

  logic wr_en;
  logic pop_en;
  logic baud_done;
  logic can_pop;

  // Readiness and pop both look at registered occupancy, so a byte written
  // into an empty FIFO cannot be popped until the following edge.
  assign din_ready = (count_reg < DEPTH_C);
  assign wr_en     = din_valid && din_ready;
  assign baud_done = (baud_reg == BAUD_LAST);
  assign can_pop   = en && (count_reg != '0);
  assign pop_en    = can_pop && ((state_reg == IDLE) || ((state_reg == STOP) && baud_done));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          baud_reg <= '0;
          if (pop_en) begin
            state_reg <= START;
            shift_reg <= mem[rd_ptr_reg];
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_reg   <= DATA;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            // Chain straight into the next start bit when more data is waiting.
            if (pop_en) begin
              state_reg <= START;
              shift_reg <= mem[rd_ptr_reg];
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = tx_reg;
  assign out_state = state_reg;
  assign out_count = count_reg;
  assign busy      = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_uarttx_buffered.sv
// Randomized bench for uarttx_buffered: a frame-level model (byte queue plus a
// position inside a 10-bit frame) predicts every output on every clock.
module tb_uarttx_buffered;

  localparam int BM    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BM;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic [1:0] out_state;
  logic [2:0] out_count;

  uarttx_buffered #(.BAUD_MULT(BM), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .out_state (out_state),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending bytes, plus the byte on the wire and how many
  // clocks into its 160-clock frame we are.
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         pos = 0;
  logic [7:0] cur = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    int idx;
    idx = p / BM;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [1:0] frame_phase(input int p);
    if (p < BM) return 2'd1;
    if (p < 9 * BM) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    bit wr;
    bit frame_end;
    wr        = v && (q.size() < DEPTH);
    frame_end = active && (pos == FRAME - 1);
    if (frame_end) $display("frame done byte=0x%02h t=%0t", cur, $time);
    if ((!active || frame_end) && e && (q.size() > 0)) begin
      cur    = q.pop_front();
      active = 1'b1;
      pos    = 0;
    end else if (active) begin
      if (frame_end) active = 1'b0;
      else pos++;
    end
    if (wr) q.push_back(d);
  endtask

  task automatic compare_all();
    check("tx",        32'(tx),        32'(active ? frame_bit(cur, pos) : 1'b1));
    check("out_state", 32'(out_state), 32'(active ? frame_phase(pos) : 2'd0));
    check("out_count", 32'(out_count), 32'(q.size()));
    check("busy",      32'(busy),      32'(active || (q.size() > 0)));
    check("din_ready", 32'(din_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    din_valid = v;
    din       = d;
    en        = e;
    @(posedge clk);
    model_step(v, d, e);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input logic e);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},    32'(tx),        32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ready"}, 32'(din_ready), 32'd1);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    check({tag, "_state"}, 32'(out_state), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    q.delete();
    active = 1'b0;
    pos    = 0;
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_hold"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single byte with en high.
    cycle(1'b1, 8'h45, 1'b1);
    idle_cycles(FRAME + 10, 1'b1);

    // Back-to-back bytes.
    cycle(1'b1, 8'h45, 1'b1);
    cycle(1'b1, 8'hD6, 1'b1);
    idle_cycles(2 * FRAME + 10, 1'b1);

    // Fill with en low: five pushes, the fifth is refused.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + 8'(i * 17)), 1'b0);
    check("full_count", 32'(out_count), 32'd4);
    check("full_ready", 32'(din_ready), 32'd0);
    idle_cycles(4 * FRAME + 10, 1'b1);

    // Enable dropped during the data bits of the first frame.
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    idle_cycles(40, 1'b1);
    idle_cycles(FRAME + 20, 1'b0);
    check("endrop_count", 32'(out_count), 32'd1);
    check("endrop_tx",    32'(tx),        32'd1);
    idle_cycles(FRAME + 10, 1'b1);

    // Reset while data bit 3 is on the wire.
    cycle(1'b1, 8'h96, 1'b1);
    cycle(1'b1, 8'h69, 1'b1);
    for (int i = 0; i < 200 && !(active && pos >= BM + 3 * BM + 5); i++) cycle(1'b0, 8'h00, 1'b1);
    check("midframe_reached", 32'(active && pos >= BM + 3 * BM + 5), 32'd1);
    async_reset("midrst");
    idle_cycles(5, 1'b1);

    // Random traffic with occasional enable toggles.
    begin
      logic e_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 299) == 0) e_r = ~e_r;
        cycle(($urandom_range(0, 99) < 2), 8'($urandom), e_r);
      end
    end
    idle_cycles(5 * FRAME, 1'b1);
    check("drain_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uarttx_buffered.md
UARTTX_BUFFERED -- requirements
Module: uarttx_buffered

Interface
REQ-001 SHALL have parameter BAUD_MULT, default 10416, clocks per UART bit (9600 baud at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries in transmit FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  transmit enable; gates start of new frames only.
REQ-006 SHALL have port din  input  8  byte to transmit.
REQ-007 SHALL have port din_valid  input  1  din presented this cycle.
REQ-008 SHALL have port din_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-011 SHALL have port out_state  output  2  FSM state for debug: 0 IDLE, 1 START, 2 DATA, 3 STOP.
REQ-012 SHALL have port out_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL accept a write on a rising edge when din_valid=1 and din_ready=1; din_ready = (occupancy < FIFO_DEPTH), combinational from registered occupancy.
REQ-014 SHALL ignore din when din_valid=1 and din_ready=0; no overwrite, no error flag.
REQ-015 SHALL keep bytes in strict FIFO order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL, on a cycle with both a write and a pop, leave occupancy unchanged; a write while full is rejected even if a pop occurs that cycle.
REQ-017 SHALL frame 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit exactly BAUD_MULT clocks on tx.
REQ-018 SHALL use a baud counter 0..BAUD_MULT-1, cleared on every state entry; a state ends when counter = BAUD_MULT-1.
REQ-019 SHALL, in IDLE, drive tx=1 and, when en=1 and occupancy>0, pop the head byte into a shift register and enter START.
REQ-020 SHALL assert tx=0 on the edge that enters START, i.e. one clock after the accepting edge when FIFO was empty and en=1.
REQ-021 SHALL in DATA shift out bits 0..7 using a 3-bit index, entering STOP after bit 7 completes.
REQ-022 SHALL at end of STOP, if en=1 and occupancy>0, pop and enter START directly (no idle gap); else enter IDLE.
REQ-023 SHALL complete a frame in progress when en falls; en only blocks the next START.
REQ-024 SHALL drive busy = (state != IDLE) or (occupancy > 0).
REQ-025 SHALL not start a frame from a byte written in the same cycle the FIFO was sampled empty; it starts the following cycle.

Reset
REQ-026 SHALL on rst=1, immediately and asynchronously: tx=1, state IDLE, baud counter 0, bit index 0, pointers 0, occupancy 0, busy=0, din_ready=1.
REQ-027 SHALL discard the partial frame and all FIFO contents on reset mid-operation; line returns high without a stop bit.
REQ-028 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Verification (BAUD_MULT=16 unless stated)
REQ-029 SHALL cover single byte: push 0x45, en=1 -> tx low 16 clks, then 1,0,1,0,0,0,1,0 at 16 clks each, stop high 16 clks; frame 160 clks; busy falls after stop.
REQ-030 SHALL cover back-to-back: push 0x45,0xD6 on consecutive cycles -> second start bit begins the clock after first stop ends; 320 clks of continuous busy.
REQ-031 SHALL cover full FIFO: en=0, push 5 bytes -> first 4 accepted, din_ready=0 on 5th, out_count=4; then en=1 -> 4 frames in push order.
REQ-032 SHALL cover enable drop: deassert en during DATA of frame 1 with 2 bytes queued -> frame 1 completes, tx stays 1, out_count=1, out_state=0.
REQ-033 SHALL cover reset mid-frame: assert rst during DATA bit 3 -> same cycle tx=1, busy=0, din_ready=1, out_count=0, out_state=0.
REQ-034 SHALL cover loopback at BAUD_MULT=10416: tx wired to uartrx_simple rx with en=1 -> dout=0x45 then 0xD6.
